// File: rtl/quadra_result_buffer.sv
// Result collector at the exit of a fixed-latency, non-stallable pipeline.
// Issue credits are granted only when a buffer slot is guaranteed, so results
// emerging from the free-running pipeline can always be stored.
module quadra_result_buffer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 6,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic             pipe_valid_i,
  input  logic [WIDTH-1:0] pipe_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    count_o,
  output logic             error_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // A zero-latency pipeline would return a result before its issue is counted.
  if (LATENCY == 0) begin : g_bad_latency
    $error("quadra_result_buffer: LATENCY must be at least 1");
  end
  if (DEPTH == 0) begin : g_bad_depth
    $error("quadra_result_buffer: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             issue_ready_q, out_valid_q, error_q, error_d;

  logic fire, pop, room, wr, ret;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode; all terms come from registered state or plain inputs.
  always_comb begin
    fire = issue_valid_i && issue_ready_q;
    pop  = out_valid_q && out_ready_i;
    ret  = pipe_valid_i && (inflight_q != '0);
    room = (inflight_q != '0) && ((count_q < CW'(DEPTH)) || pop);
    wr   = pipe_valid_i && room;
  end

  // Next-state computation for counters, pointers and the sticky error.
  always_comb begin
    credits_d  = credits_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    error_d    = error_q | (pipe_valid_i && !room);

    unique case ({fire, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase

    unique case ({fire, ret})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // State registers; flags are registered from the next-state counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      credits_q     <= CW'(DEPTH);
      inflight_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      error_q       <= 1'b0;
      issue_ready_q <= 1'b1;
      out_valid_q   <= 1'b0;
    end else begin
      credits_q     <= credits_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      error_q       <= error_d;
      issue_ready_q <= (credits_d != '0);
      out_valid_q   <= (count_d != '0);
    end
  end

  // Result storage; cleared on reset so the output word reads zero.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr_q] <= pipe_data_i;
    end
  end

  assign issue_ready_o = issue_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = mem[rd_ptr_q];
  assign count_o       = count_q;
  assign error_o       = error_q;

endmodule

// File: doc/quadra_result_buffer.md
# quadra_result_buffer

Output-side collector for fixed-latency, non-stallable pipelines in the Quadratic Approximation Unit. Pipeline stages built from delay chains cannot stall. This block sits at the pipeline exit and turns the free-running result stream back into a valid/ready interface. It grants issue credits upstream only when buffer space is guaranteed, so no result is ever lost under downstream backpressure.

## Interface
- WIDTH, 16, bit width of result data.
- LATENCY, 4, issue-to-result latency of the attached pipeline in cycles; informational, sizing rule only.
- DEPTH, 6, result storage entries, >= 1. Sustained full throughput requires DEPTH >= LATENCY+2.

Ports:
- clk  input  1 (ck_t)  clock, rising edge.
- rst_b  input  1 (rs_t)  asynchronous active-low reset.
- issue_valid_i  input  1  upstream wants to launch an operation into the pipeline.
- issue_ready_o  output  1  credit available; an issue fires when issue_valid_i && issue_ready_o.
- pipe_valid_i  input  1  pipeline result present this cycle.
- pipe_data_i  input  WIDTH  pipeline result data.
- out_valid_o  output  1  buffer holds at least one result.
- out_data_o  output  WIDTH  oldest stored result.
- out_ready_i  input  1  downstream accepts; a pop happens when out_valid_o && out_ready_i.
- count_o  output  $clog2(DEPTH+1)  number of stored results.
- error_o  output  1  sticky protocol error.

## Operation
- Storage is a DEPTH-entry register FIFO with rd_ptr, wr_ptr and count.
- Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- Credit counter credits:
  - reset value DEPTH;
  - -1 on issue fire, +1 on pop, unchanged when both happen in the same cycle.
  - Saturates in range 0..DEPTH by construction.
- issue_ready_o = (credits != 0), decoded from registers only, with no combinational path from issue_valid_i or out_ready_i.
- Inflight counter: +1 on issue fire, -1 on pipe_valid_i, unchanged when both happen; range 0..DEPTH.
- Write rule: pipe_valid_i stores pipe_data_i at wr_ptr if inflight != 0 and (count < DEPTH or pop this cycle).
- Otherwise the result is dropped and error_o sets. Case a: pipe_valid_i with inflight == 0. Case b: overflow.
- error_o stays high until reset; normal operation continues after an error.
- out_valid_o = (count != 0); out_data_o = mem[rd_ptr].
- No write-to-read bypass: when count == 0, out_valid_o stays low in the write cycle.
- Simultaneous write and pop: count is unchanged and both pointers advance.
- Results leave in arrival order; the block never reorders or duplicates.
- Reset values: issue_ready_o=1, out_valid_o=0, count_o=0, error_o=0, credits=DEPTH, inflight=0, pointers 0. Storage contents are don't-care; out_data_o is 0 after reset.
- Reset asserted mid-operation clears all state immediately, independent of clk. Any result arriving after reset release for an issue made before reset is an error (case a).

## Timing
- Result in: pipe_valid_i at edge n gives out_valid_o high and out_data_o valid after edge n+1, i.e. 1-cycle buffer latency.
- Pop at edge n: count_o decrements and the next entry is presented after n+1. Back-to-back pops drain 1 entry per cycle.
- Credit return: a pop at edge n raises issue_ready_o after edge n+1 if credits was 0.
- Issue-to-credit-return round trip is LATENCY+2 cycles, hence the DEPTH rule.
- count_o, error_o and issue_ready_o are registered-state outputs, stable for the whole cycle.

## Test plan
- Reset, then idle 10 cycles.
  - Required: issue_ready_o=1, out_valid_o=0, count_o=0, error_o=0 throughout.
- Single transfer (WIDTH=16, LATENCY=3, DEPTH=4): issue at cycle 0; pipe_valid_i with 0x1234 at cycle 3; out_ready_i=1.
  - Required: out_valid_o=1 with 0x1234 only in cycle 4.
  - Required: credits return to 4; count_o goes 0,1,0.
- Backpressure, out_ready_i=0: issue 6 back-to-back; results 0xA,0xB,0xC,0xD.
  - Required: issue_ready_o low after the 4th fire and only 4 issues accepted; count_o=4.
  - Then raise out_ready_i. Required: 0xA,0xB,0xC,0xD on consecutive cycles; issue_ready_o re-rises 1 cycle after the first pop.
- Throughput (LATENCY=3, DEPTH=5), issue_valid_i and out_ready_i held high for 50 cycles.
  - Required: issue_ready_o never drops; one result per cycle; count_o <= 1.
- Spurious result: pipe_valid_i with 0xBEEF while inflight=0.
  - Required: error_o=1 next cycle; 0xBEEF never appears; error_o stays 1 until rst_b low.
- Async reset with count_o=3 and 2 inflight: drop rst_b between clock edges.
  - Required: all outputs at reset values immediately.
  - After release, the 2 late pipeline results set error_o and are not stored.
